// File: rtl/params_pkg.sv
// Shared AXI sizing plus write-arbiter types.
package params_pkg;
  localparam int AXI_ID_WIDTH   = 6;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 1024;
  localparam int AXI_LEN_WIDTH  = 8;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not named by ptr wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt,
  output logic       any
);
  assign any = |req;
  assign gnt = (&req) ? ~ptr : req[1];
endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write arbiter: one whole AW/W/B transaction at a time,
// combinational pass-through once granted, sticky burst-length error flag.
module axi_wr_arbiter
  import params_pkg::*;
#(
  parameter int ID_W   = AXI_ID_WIDTH,
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int LEN_W  = AXI_LEN_WIDTH
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                S0_AWVALID,
  output logic                S0_AWREADY,
  input  logic [ID_W-1:0]     S0_AWID,
  input  logic [ADDR_W-1:0]   S0_AWADDR,
  input  logic [LEN_W-1:0]    S0_AWLEN,
  input  logic                S0_WVALID,
  output logic                S0_WREADY,
  input  logic [DATA_W-1:0]   S0_WDATA,
  input  logic [DATA_W/8-1:0] S0_WSTRB,
  input  logic                S0_WLAST,
  output logic                S0_BVALID,
  input  logic                S0_BREADY,
  output logic [ID_W-1:0]     S0_BID,
  output logic [1:0]          S0_BRESP,
  input  logic                S1_AWVALID,
  output logic                S1_AWREADY,
  input  logic [ID_W-1:0]     S1_AWID,
  input  logic [ADDR_W-1:0]   S1_AWADDR,
  input  logic [LEN_W-1:0]    S1_AWLEN,
  input  logic                S1_WVALID,
  output logic                S1_WREADY,
  input  logic [DATA_W-1:0]   S1_WDATA,
  input  logic [DATA_W/8-1:0] S1_WSTRB,
  input  logic                S1_WLAST,
  output logic                S1_BVALID,
  input  logic                S1_BREADY,
  output logic [ID_W-1:0]     S1_BID,
  output logic [1:0]          S1_BRESP,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [ID_W-1:0]     M_AWID,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic [LEN_W-1:0]    M_AWLEN,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WLAST,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  input  logic [ID_W-1:0]     M_BID,
  input  logic [1:0]          M_BRESP,
  output logic                GRANT,
  output logic                BUSY,
  output logic                LEN_ERR
);
  wr_arb_state_t    state_q, state_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic             len_err_q, len_err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0]               aw_valid, w_valid, w_last, b_ready;
  logic [NUM_REQ-1:0]               aw_ready, w_ready, b_valid, gnt_oh;
  logic [NUM_REQ-1:0][ID_W-1:0]     aw_id;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   aw_addr;
  logic [NUM_REQ-1:0][LEN_W-1:0]    aw_len;
  logic [NUM_REQ-1:0][DATA_W-1:0]   w_data;
  logic [NUM_REQ-1:0][DATA_W/8-1:0] w_strb;

  assign aw_valid = {S1_AWVALID, S0_AWVALID};
  assign aw_id    = {S1_AWID,    S0_AWID};
  assign aw_addr  = {S1_AWADDR,  S0_AWADDR};
  assign aw_len   = {S1_AWLEN,   S0_AWLEN};
  assign w_valid  = {S1_WVALID,  S0_WVALID};
  assign w_data   = {S1_WDATA,   S0_WDATA};
  assign w_strb   = {S1_WSTRB,   S0_WSTRB};
  assign w_last   = {S1_WLAST,   S0_WLAST};
  assign b_ready  = {S1_BREADY,  S0_BREADY};

  logic arb_gnt, arb_any;
  rr_arb2 u_rr (.req(aw_valid), .ptr(ptr_q), .gnt(arb_gnt), .any(arb_any));

  logic in_addr, in_data, in_resp, aw_hs, w_hs, b_hs, beat_last;
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);
  assign gnt_oh  = grant_q ? 2'b10 : 2'b01;

  // Payloads always follow the granted requester; only VALID/READY are gated.
  assign M_AWVALID = in_addr & aw_valid[grant_q];
  assign M_AWID    = aw_id[grant_q];
  assign M_AWADDR  = aw_addr[grant_q];
  assign M_AWLEN   = aw_len[grant_q];
  assign aw_ready  = {NUM_REQ{in_addr & M_AWREADY}} & gnt_oh;
  assign aw_hs     = M_AWVALID & M_AWREADY;

  assign M_WVALID = in_data & w_valid[grant_q];
  assign M_WDATA  = w_data[grant_q];
  assign M_WSTRB  = w_strb[grant_q];
  assign M_WLAST  = w_last[grant_q];
  assign w_ready  = {NUM_REQ{in_data & M_WREADY}} & gnt_oh;
  assign w_hs     = M_WVALID & M_WREADY;

  assign M_BREADY = in_resp & b_ready[grant_q];
  assign b_valid  = {NUM_REQ{in_resp & M_BVALID}} & gnt_oh;
  assign b_hs     = M_BVALID & M_BREADY;

  assign {S1_AWREADY, S0_AWREADY} = aw_ready;
  assign {S1_WREADY,  S0_WREADY}  = w_ready;
  assign {S1_BVALID,  S0_BVALID}  = b_valid;
  assign S0_BID   = M_BID;
  assign S1_BID   = M_BID;
  assign S0_BRESP = M_BRESP;
  assign S1_BRESP = M_BRESP;

  assign GRANT   = grant_q;
  assign BUSY    = (state_q != IDLE);
  assign LEN_ERR = len_err_q;

  // Counter is one bit wider than AWLEN so a runaway burst cannot wrap to a match.
  assign beat_last = (cnt_q == {1'b0, len_q});

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: if (arb_any) begin
        grant_d = arb_gnt;
        state_d = ADDR;
      end
      ADDR: if (aw_hs) begin
        len_d   = aw_len[grant_q];
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (w_hs) begin
        cnt_d = cnt_q + (LEN_W+1)'(1);
        if (M_WLAST != beat_last) len_err_d = 1'b1;
        if (M_WLAST) state_d = RESP;
      end
      RESP: if (b_hs) begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      ptr_q     <= 1'b1;
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: requester/slave agents, a per-cycle reference
// model of the arbitration rules, and directed scenarios with literal checks.
module tb_axi_wr_arbiter;
  import params_pkg::*;
  localparam int IW = AXI_ID_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int LW = AXI_LEN_WIDTH;

  typedef struct { int id; int addr; int len; int nb; bit early; } txn_t;

  logic ACLK, ARESETN;
  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [1:0][IW-1:0]   s_awid, s_bid;
  logic [1:0][AW-1:0]   s_awaddr;
  logic [1:0][LW-1:0]   s_awlen;
  logic [1:0][DW-1:0]   s_wdata;
  logic [1:0][DW/8-1:0] s_wstrb;
  logic [1:0][1:0]      s_bresp;
  logic M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_WLAST, M_BVALID, M_BREADY;
  logic [IW-1:0] M_AWID, M_BID;
  logic [AW-1:0] M_AWADDR;
  logic [LW-1:0] M_AWLEN;
  logic [DW-1:0] M_WDATA;
  logic [DW/8-1:0] M_WSTRB;
  logic [1:0] M_BRESP;
  logic GRANT, BUSY, LEN_ERR;

  axi_wr_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]), .S0_AWID(s_awid[0]),
    .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]), .S0_WVALID(s_wvalid[0]),
    .S0_WREADY(s_wready[0]), .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]),
    .S0_WLAST(s_wlast[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
    .S0_BID(s_bid[0]), .S0_BRESP(s_bresp[0]),
    .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]), .S1_AWID(s_awid[1]),
    .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]), .S1_WVALID(s_wvalid[1]),
    .S1_WREADY(s_wready[1]), .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]),
    .S1_WLAST(s_wlast[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
    .S1_BID(s_bid[1]), .S1_BRESP(s_bresp[1]),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWID(M_AWID),
    .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BID(M_BID), .M_BRESP(M_BRESP),
    .GRANT(GRANT), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdata_of(input int id, input int beat);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = 32'hA5A50000 ^ 32'(id << 8) ^ 32'(beat) ^ 32'(i << 20);
    return v;
  endfunction

  // ---------------- agents ----------------
  txn_t q0[$], q1[$];
  int ph[2], beat[2], bcnt[2], bdelay[2];
  int rst_hold = 2, aw_stall = 0, sph = 0;
  bit w_tog = 0;
  logic [1:0] bresp_cfg = AXI_RESP_OKAY;
  int fwd_beats = 0, bwait = 0, early_rdy = 0, s1_act = 0;
  int grant_log[$];
  logic [DW-1:0] got_q[$];
  logic [IW-1:0] b_id_got[2];
  logic [1:0] b_resp_got[2];

  function automatic int qsize(input int n);
    return (n == 0) ? q0.size() : q1.size();
  endfunction
  function automatic txn_t qfront(input int n);
    txn_t r;
    r = '{0, 0, 0, 1, 1'b0};
    if (n == 0 && q0.size() > 0) r = q0[0];
    if (n == 1 && q1.size() > 0) r = q1[0];
    return r;
  endfunction
  task automatic qpush(input int n, input txn_t t);
    if (n == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  initial begin
    logic [1:0] hs_aw, hs_w, hs_b;
    logic m_aw_hs, m_w_hs, m_b_hs, m_wlast_s, stall_dec;
    logic [IW-1:0] m_awid_s, sid;
    txn_t t;
    ARESETN = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_wdata = '0; s_wstrb = '0;
    M_AWREADY = 1'b1; M_WREADY = 1'b1; M_BVALID = 1'b0; M_BID = '0; M_BRESP = '0;
    sid = '0;
    for (int n = 0; n < 2; n++) begin ph[n] = 0; beat[n] = 0; bcnt[n] = 0; bdelay[n] = 0; end
    forever begin
      @(negedge ACLK);
      hs_aw = s_awvalid & s_awready;
      hs_w  = s_wvalid & s_wready;
      hs_b  = s_bvalid & s_bready;
      m_aw_hs = M_AWVALID && M_AWREADY;
      m_w_hs  = M_WVALID && M_WREADY;
      m_b_hs  = M_BVALID && M_BREADY;
      m_awid_s = M_AWID;
      m_wlast_s = M_WLAST;
      stall_dec = M_AWVALID && !M_AWREADY && aw_stall > 0;
      if (m_aw_hs) grant_log.push_back(int'(GRANT));
      if (m_w_hs) begin fwd_beats++; got_q.push_back(M_WDATA); end
      if (M_BVALID && !M_BREADY) bwait++;
      if (s_awready[1] || s_wready[1] || s_bvalid[1]) s1_act++;
      for (int n = 0; n < 2; n++) begin
        if (ph[n] == 0 && s_wvalid[n] && s_wready[n]) early_rdy++;
        if (hs_b[n]) begin b_id_got[n] = s_bid[n]; b_resp_got[n] = s_bresp[n]; end
      end
      @(posedge ACLK);
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        ARESETN = 1'b0;
        q0.delete(); q1.delete();
        for (int n = 0; n < 2; n++) begin ph[n] = 0; beat[n] = 0; bcnt[n] = 0; end
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_wlast = '0;
        sph = 0; M_BVALID = 1'b0;
        continue;
      end
      ARESETN = 1'b1;
      for (int n = 0; n < 2; n++) begin
        t = qfront(n);
        if (ph[n] == 0 && hs_aw[n]) begin
          ph[n] = 1; beat[n] = 0;
        end else if (ph[n] == 1 && hs_w[n]) begin
          if (beat[n] == t.nb - 1) begin ph[n] = 2; bcnt[n] = bdelay[n]; end
          else beat[n]++;
        end else if (ph[n] == 2) begin
          if (hs_b[n]) begin
            ph[n] = 0; beat[n] = 0;
            if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end else if (bcnt[n] > 0) bcnt[n]--;
        end
        t = qfront(n);
        s_awvalid[n] = (ph[n] == 0) && (qsize(n) > 0);
        s_awid[n]    = IW'(t.id);
        s_awaddr[n]  = AW'(t.addr);
        s_awlen[n]   = LW'(t.len);
        s_wvalid[n]  = (ph[n] == 1) || ((ph[n] == 0) && (qsize(n) > 0) && t.early);
        s_wdata[n]   = wdata_of(t.id, beat[n]);
        s_wstrb[n]   = '1;
        s_wlast[n]   = (beat[n] == t.nb - 1);
        s_bready[n]  = (ph[n] == 2) && (bcnt[n] == 0);
      end
      if (stall_dec) aw_stall--;
      if (sph == 0 && m_aw_hs) begin sph = 1; sid = m_awid_s; end
      else if (sph == 1 && m_w_hs && m_wlast_s) sph = 2;
      else if (sph == 2 && m_b_hs) sph = 0;
      M_AWREADY = (aw_stall == 0);
      M_WREADY  = w_tog ? ~M_WREADY : 1'b1;
      M_BVALID  = (sph == 2);
      M_BID     = sid;
      M_BRESP   = bresp_cfg;
    end
  end

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 address, 2 data, 3 response; mlast = last served requester.
  int mph, mg, mlast, mlen, mbeats;
  bit merr, mv = 0;

  always @(negedge ACLK) begin
    logic [1:0] e_awr, e_wr, e_bv;
    logic e_awv, e_wv, e_br;
    if (mv) begin
      e_awv = (mph == 1) && s_awvalid[mg];
      e_wv  = (mph == 2) && s_wvalid[mg];
      e_br  = (mph == 3) && s_bready[mg];
      e_awr = '0; e_wr = '0; e_bv = '0;
      if (mph == 1 && M_AWREADY) e_awr[mg] = 1'b1;
      if (mph == 2 && M_WREADY)  e_wr[mg]  = 1'b1;
      if (mph == 3 && M_BVALID)  e_bv[mg]  = 1'b1;
      chk("m_awvalid", 64'(M_AWVALID), 64'(e_awv));
      if (e_awv) begin
        chk("m_awid", 64'(M_AWID), 64'(s_awid[mg]));
        chk("m_awaddr", 64'(M_AWADDR), 64'(s_awaddr[mg]));
        chk("m_awlen", 64'(M_AWLEN), 64'(s_awlen[mg]));
      end
      chk("s_awready", 64'(s_awready), 64'(e_awr));
      chk("m_wvalid", 64'(M_WVALID), 64'(e_wv));
      if (e_wv) begin
        chk("m_wdata_eq", 64'(M_WDATA == s_wdata[mg]), 64'd1);
        chk("m_wstrb_eq", 64'(M_WSTRB == s_wstrb[mg]), 64'd1);
        chk("m_wlast", 64'(M_WLAST), 64'(s_wlast[mg]));
      end
      chk("s_wready", 64'(s_wready), 64'(e_wr));
      chk("s_bvalid", 64'(s_bvalid), 64'(e_bv));
      if (e_bv != 0) begin
        chk("s_bid", 64'(s_bid[mg]), 64'(M_BID));
        chk("s_bresp", 64'(s_bresp[mg]), 64'(M_BRESP));
      end
      chk("m_bready", 64'(M_BREADY), 64'(e_br));
      chk("busy", 64'(BUSY), 64'(mph != 0));
      if (mph != 0) chk("grant", 64'(GRANT), 64'(mg));
      chk("len_err", 64'(LEN_ERR), 64'(merr));
    end
    if (!ARESETN) begin
      mph = 0; mg = 0; mlast = 1; merr = 0; mlen = 0; mbeats = 0; mv = 1;
    end else if (mv) begin
      case (mph)
        0: if (s_awvalid != 2'b00) begin
          mg  = (s_awvalid == 2'b11) ? ((mlast == 0) ? 1 : 0) : int'(s_awvalid[1]);
          mph = 1;
        end
        1: if (s_awvalid[mg] && M_AWREADY) begin mlen = int'(s_awlen[mg]); mbeats = 0; mph = 2; end
        2: if (s_wvalid[mg] && M_WREADY) begin
          if (s_wlast[mg] != (mbeats == mlen)) merr = 1;
          mbeats++;
          if (s_wlast[mg]) mph = 3;
        end
        default: if (M_BVALID && s_bready[mg]) begin mlast = mg; mph = 0; end
      endcase
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic cyc();
    @(negedge ACLK);
    #2;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      cyc();
      ok = (q0.size() == 0) && (q1.size() == 0) && (ph[0] == 0) && (ph[1] == 0) && !BUSY && (sph == 0);
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for idle", nm);
    end
  endtask

  task automatic do_reset();
    rst_hold = 1;
    cyc();
    cyc();
  endtask

  initial begin
    bit hit;
    repeat (4) cyc();
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_grant", 64'(GRANT), 0);
    chk("rst_len_err", 64'(LEN_ERR), 0);
    chk("rst_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, s_awready, s_wready, s_bvalid}), 0);

    // S0 alone, 4-beat burst
    fwd_beats = 0; s1_act = 0; got_q.delete();
    qpush(0, '{5, 32'h1000, 3, 4, 1'b0});
    cyc();
    chk("t1_no_aw_in_idle", 64'(M_AWVALID), 0);
    cyc();
    chk("t1_aw_fwd", 64'(M_AWVALID), 1);
    chk("t1_awaddr", 64'(M_AWADDR), 64'h1000);
    chk("t1_awid", 64'(M_AWID), 5);
    wait_done("t1");
    chk("t1_beats", 64'(fwd_beats), 4);
    for (int i = 0; i < 4; i++) chk("t1_data_order", 64'(got_q[i] == wdata_of(5, i)), 1);
    chk("t1_bid", 64'(b_id_got[0]), 5);
    chk("t1_bresp", 64'(b_resp_got[0]), 0);
    chk("t1_s1_idle", 64'(s1_act), 0);
    chk("t1_len_err", 64'(LEN_ERR), 0);

    // both requesting from reset: alternation 0,1,0,1
    do_reset();
    grant_log.delete();
    qpush(0, '{1, 32'h2000, 0, 1, 1'b0}); qpush(1, '{2, 32'h3000, 0, 1, 1'b0});
    qpush(0, '{3, 32'h2040, 0, 1, 1'b0}); qpush(1, '{4, 32'h3040, 0, 1, 1'b0});
    wait_done("t2");
    chk("t2_ngrants", 64'(grant_log.size()), 4);
    if (grant_log.size() == 4) begin
      chk("t2_g0", 64'(grant_log[0]), 0);
      chk("t2_g1", 64'(grant_log[1]), 1);
      chk("t2_g2", 64'(grant_log[2]), 0);
      chk("t2_g3", 64'(grant_log[3]), 1);
    end

    // backpressure on every channel
    aw_stall = 3; w_tog = 1; bdelay[1] = 2;
    fwd_beats = 0; bwait = 0; got_q.delete();
    qpush(1, '{9, 32'h4000, 3, 4, 1'b0});
    wait_done("t3");
    chk("t3_beats", 64'(fwd_beats), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t3_data_order", 64'(got_q[i] == wdata_of(9, i)), 1);
    chk("t3_bwait", 64'(bwait), 2);
    chk("t3_bid", 64'(b_id_got[1]), 9);
    w_tog = 0; bdelay[1] = 0;

    // short burst: WLAST early on len=2
    bresp_cfg = AXI_RESP_SLVERR; fwd_beats = 0;
    qpush(0, '{6, 32'h5000, 2, 2, 1'b0});
    wait_done("t4a");
    chk("t4_len_err_set", 64'(LEN_ERR), 1);
    chk("t4_slverr", 64'(b_resp_got[0]), 64'(AXI_RESP_SLVERR));
    chk("t4_beats", 64'(fwd_beats), 2);
    bresp_cfg = AXI_RESP_OKAY;
    qpush(1, '{7, 32'h5100, 1, 2, 1'b0});
    wait_done("t4b");
    chk("t4_len_err_sticky", 64'(LEN_ERR), 1);
    chk("t4_next_bid", 64'(b_id_got[1]), 7);
    chk("t4_next_bresp", 64'(b_resp_got[1]), 0);

    // reset in the middle of an 8-beat burst
    qpush(0, '{8, 32'h6000, 7, 8, 1'b0});
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      cyc();
      hit = (ph[0] == 1) && (beat[0] == 1);
    end
    chk("t5_reached_beat2", 64'(hit), 1);
    do_reset();
    chk("t5_busy", 64'(BUSY), 0);
    chk("t5_len_err", 64'(LEN_ERR), 0);
    chk("t5_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, s_awready, s_wready, s_bvalid}), 0);
    grant_log.delete();
    qpush(1, '{10, 32'h7000, 0, 1, 1'b0});
    wait_done("t5");
    chk("t5_ngrants", 64'(grant_log.size()), 1);
    if (grant_log.size() == 1) chk("t5_grant_s1", 64'(grant_log[0]), 1);
    chk("t5_bid", 64'(b_id_got[1]), 10);

    // S1 offers W before AW completes
    aw_stall = 2; early_rdy = 0; fwd_beats = 0; got_q.delete();
    qpush(1, '{11, 32'h8000, 1, 2, 1'b1});
    wait_done("t6");
    chk("t6_no_early_wready", 64'(early_rdy), 0);
    chk("t6_beats", 64'(fwd_beats), 2);
    if (got_q.size() > 0) chk("t6_first_beat", 64'(got_q[0] == wdata_of(11, 0)), 1);
    chk("t6_len_err", 64'(LEN_ERR), 0);
    chk("t6_bid", 64'(b_id_got[1]), 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
